sn74121_oneshot: RTL and testbench

- Cycle-accurate emulation of one SN74121 monostable multivibrator, synchronous to the master clock.
- It is the pulse source that feeds the edge-sensitive clock and clear inputs of the flip-flop emulations: it converts a trigger edge into a fixed-width positive pulse on q and a complementary pulse on q_n.
- Pulse width is a parameter counted in mclk cycles; there is no RC model.
- Used wherever the processor logic uses a delay or pulse one-shot.

---
 rtl/sn74121_oneshot_pkg.sv | 28 ++
 rtl/sn74121_oneshot_if.sv | 26 ++
 rtl/sn74121_infilt.sv | 44 ++++
 rtl/sn74121_oneshot.sv | 136 +++++++++++++
 tb/tb_sn74121_oneshot.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/sn74121_oneshot_pkg.sv
// Shared definitions for the SN74121 one-shot emulation: state encoding,
// counter sizing helper and input filter reset levels.
package sn74121_oneshot_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PULSE   = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  // Filter outputs come out of reset at the inactive level of each input.
  localparam logic A_N_FILT_RST = 1'b1;
  localparam logic B_FILT_RST   = 1'b0;

  // Counter must hold the largest of the pulse length, the recovery length
  // and the startup hold-off (FILT_CYCLES+1).
  function automatic int unsigned cnt_width(input int unsigned pulse,
                                            input int unsigned recov,
                                            input int unsigned filt);
    int unsigned mx;
    mx = pulse;
    if (recov > mx) mx = recov;
    if (filt + 1 > mx) mx = filt + 1;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/sn74121_oneshot_if.sv
// Trigger inputs and pulse outputs of one SN74121 emulation.
interface sn74121_oneshot_if;

  logic a1_n;
  logic a2_n;
  logic b;
  logic q;
  logic q_n;

  modport master (
    output a1_n,
    output a2_n,
    output b,
    input  q,
    input  q_n
  );

  modport slave (
    input  a1_n,
    input  a2_n,
    input  b,
    output q,
    output q_n
  );

endinterface

// File: rtl/sn74121_infilt.sv
// Single-bit stability filter: the output follows the input only after the
// input has differed from the output for FILT_CYCLES consecutive samples.
module sn74121_infilt #(
  parameter int unsigned FILT_CYCLES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES);

  logic       out_q, out_d;
  logic [3:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the current output.
  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (d_i != out_q) begin
      if (cnt_q + 4'd1 == FILT_LAST) begin
        out_d = d_i;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RST_VAL;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o = out_q;

endmodule

// File: rtl/sn74121_oneshot.sv
// SN74121 monostable emulation clocked by mclk: filtered trigger edge in,
// fixed-width registered pulse out on q / q_n.
// Optional SN74121_RETRIG_EN: trigger events during the pulse reload the
// pulse counter (SN74122-style retriggering).
module sn74121_oneshot
  import sn74121_oneshot_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES    = 10,
  parameter int unsigned RECOVERY_CYCLES = 2,
  parameter int unsigned FILT_CYCLES     = 2
) (
  input  logic                mclk,
  input  logic                mrst,
  sn74121_oneshot_if.slave    bus
);

  localparam int unsigned CW = cnt_width(PULSE_CYCLES, RECOVERY_CYCLES, FILT_CYCLES);

  localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] REC_LOAD     = CW'((RECOVERY_CYCLES == 0) ? 0 : RECOVERY_CYCLES - 1);
  localparam logic [CW-1:0] STARTUP_LAST = CW'(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

`ifdef SN74121_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          a1_n_f, a2_n_f, b_f;
  logic          trig, trig_evt;
  logic          trig_prev_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          qn_q;

  sn74121_infilt #(.FILT_CYCLES(FILT_CYCLES), .RST_VAL(A_N_FILT_RST)) u_filt_a1 (
    .clk   (mclk),
    .rst_n (mrst),
    .d_i   (bus.a1_n),
    .q_o   (a1_n_f)
  );

  sn74121_infilt #(.FILT_CYCLES(FILT_CYCLES), .RST_VAL(A_N_FILT_RST)) u_filt_a2 (
    .clk   (mclk),
    .rst_n (mrst),
    .d_i   (bus.a2_n),
    .q_o   (a2_n_f)
  );

  sn74121_infilt #(.FILT_CYCLES(FILT_CYCLES), .RST_VAL(B_FILT_RST)) u_filt_b (
    .clk   (mclk),
    .rst_n (mrst),
    .d_i   (bus.b),
    .q_o   (b_f)
  );

  // Rising edge of the combined trigger term covers all datasheet cases.
  assign trig     = (!a1_n_f || !a2_n_f) && b_f;
  assign trig_evt = trig && !trig_prev_q;

  // Next-state, counter and pulse output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    case (state_q)
      // Hold-off spans the filter latency so inputs already active at
      // reset release settle into trig_prev without producing an event.
      ST_STARTUP: begin
        if (cnt_q == STARTUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (trig_evt) begin
          cnt_d   = PULSE_LOAD;
          q_d     = 1'b1;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (RETRIG && trig_evt) begin
          cnt_d = PULSE_LOAD;
        end else if (cnt_q == '0) begin
          q_d = 1'b0;
          if (RECOVERY_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = REC_LOAD;
            state_d = ST_RECOVER;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STARTUP;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase
  end

  // State, counter, edge history and output registers.
  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      state_q     <= ST_STARTUP;
      cnt_q       <= '0;
      trig_prev_q <= 1'b0;
      q_q         <= 1'b0;
      qn_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trig_prev_q <= trig;
      q_q         <= q_d;
      qn_q        <= ~q_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.q_n = qn_q;

endmodule

// File: tb/tb_sn74121_oneshot.sv
// Directed bench for sn74121_oneshot with default parameters
// (PULSE_CYCLES=10, RECOVERY_CYCLES=2, FILT_CYCLES=2).
module tb_sn74121_oneshot;

`ifdef SN74121_RETRIG_EN
  localparam int RETRIG_LEN = 15;
`else
  localparam int RETRIG_LEN = 10;
`endif

  logic mclk;
  logic mrst;
  int   tests;
  int   fails;

  sn74121_oneshot_if bus ();

  sn74121_oneshot #(
    .PULSE_CYCLES    (10),
    .RECOVERY_CYCLES (2),
    .FILT_CYCLES     (2)
  ) dut (
    .mclk (mclk),
    .mrst (mrst),
    .bus  (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input logic exp_q, input string tag);
    tests++;
    assert (bus.q === exp_q) else begin
      fails++;
      $error("FAIL %s: q=%b expected %b", tag, bus.q, exp_q);
    end
    tests++;
    assert (bus.q_n === ~exp_q) else begin
      fails++;
      $error("FAIL %s: q_n=%b expected %b", tag, bus.q_n, ~exp_q);
    end
  endtask

  // Raw trigger edge applied just after an edge: two low samples of filter
  // latency, then len cycles high, then low.
  task automatic pulse(input int len, input string tag);
    tick(); chk(1'b0, tag);
    tick(); chk(1'b0, tag);
    repeat (len) begin tick(); chk(1'b1, tag); end
    tick(); chk(1'b0, tag);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    mrst     = 1'b0;
    bus.a1_n = 1'b0;
    bus.a2_n = 1'b1;
    bus.b    = 1'b1;

    // Reset with trigger inputs already active.
    tick(); chk(1'b0, "reset_q");
    tick(); chk(1'b0, "reset_hold");
    mrst = 1'b1;
    repeat (50) begin tick(); chk(1'b0, "startup_active_inputs"); end
    bus.a1_n = 1'b1; idle(8);

    // A1 falling with B high.
    bus.a1_n = 1'b0; pulse(10, "a1_fall");
    bus.a1_n = 1'b1; idle(8);

    // A2 falling with B high.
    bus.a2_n = 1'b0; pulse(10, "a2_fall");
    bus.a2_n = 1'b1; idle(8);

    // Both A inputs falling together.
    bus.a1_n = 1'b0; bus.a2_n = 1'b0; pulse(10, "both_a_fall");
    bus.a1_n = 1'b1; bus.a2_n = 1'b1; idle(8);

    // B glitch of one cycle is filtered out; held B rise triggers.
    bus.b = 1'b0; idle(6);
    bus.a1_n = 1'b0; idle(6);
    bus.b = 1'b1; tick(); bus.b = 1'b0;
    repeat (12) begin tick(); chk(1'b0, "b_glitch"); end
    bus.b = 1'b1; pulse(10, "b_rise");
    bus.a1_n = 1'b1; idle(8);

    // Second trigger event lands in pulse cycle 5.
    bus.a1_n = 1'b0;
    tick(); chk(1'b0, "retrig_lat");
    tick(); chk(1'b0, "retrig_lat");
    bus.a1_n = 1'b1;
    tick(); chk(1'b1, "retrig_rise");
    tick(); chk(1'b1, "retrig_high");
    tick(); chk(1'b1, "retrig_high");
    bus.a1_n = 1'b0;
    repeat (RETRIG_LEN - 3) begin tick(); chk(1'b1, "retrig_high"); end
    tick(); chk(1'b0, "retrig_end");
    bus.a1_n = 1'b1; idle(8);

    // Trigger event one cycle after q falls lands in RECOVER: ignored.
    bus.a1_n = 1'b0;
    tick(); chk(1'b0, "rec1_lat");
    tick(); chk(1'b0, "rec1_lat");
    bus.a1_n = 1'b1;
    repeat (10) begin tick(); chk(1'b1, "rec1_pulse"); end
    bus.a1_n = 1'b0;
    tick(); chk(1'b0, "rec1_fall");
    repeat (20) begin tick(); chk(1'b0, "recover_ignored"); end
    bus.a1_n = 1'b1; idle(8);

    // Trigger event two cycles after q falls lands in IDLE: accepted.
    bus.a1_n = 1'b0;
    tick(); chk(1'b0, "rec2_lat");
    tick(); chk(1'b0, "rec2_lat");
    bus.a1_n = 1'b1;
    repeat (10) begin tick(); chk(1'b1, "rec2_pulse"); end
    tick(); chk(1'b0, "rec2_fall");
    bus.a1_n = 1'b0;
    tick(); chk(1'b0, "rec2_wait");
    tick(); chk(1'b0, "rec2_wait");
    tick(); chk(1'b1, "recover_accept");
    repeat (9) begin tick(); chk(1'b1, "recover_accept_high"); end
    tick(); chk(1'b0, "recover_accept_end");
    bus.a1_n = 1'b1; idle(8);

    // Asynchronous reset in pulse cycle 4, inputs left active afterwards.
    bus.a1_n = 1'b0;
    tick(); tick();
    tick(); chk(1'b1, "mid_c1");
    tick(); tick();
    tick(); chk(1'b1, "mid_c4");
    mrst = 1'b0;
    #1; chk(1'b0, "async_reset");
    tick(); chk(1'b0, "reset_held");
    mrst = 1'b1;
    repeat (50) begin tick(); chk(1'b0, "post_reset_holdoff"); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
